// File: rtl/mem_arbiter_fsm_pkg.sv
// Purpose: shared types and constants for the cache-to-RAM arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_arbiter_fsm_pkg;

    typedef logic [31:0] word_t;

    // RAM model handshake state, sampled every cycle by the arbiter.
    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_REQ  = 3'd1,
        I_REQ  = 3'd2,
        D_RESP = 3'd3,
        I_RESP = 3'd4
    } arb_state_t;

    // Latched winning request; held stable for the whole RAM access.
    typedef struct packed {
        word_t addr;
        word_t store;
        logic  wen;
        logic  isdata;
    } arb_req_t;

    localparam word_t ARB_ERR_WORD = 32'hBAD1BAD1;
    localparam int    ARB_TIMEOUT  = 15;

endpackage

// File: rtl/mem_arbiter_fsm_timeout_ctr.sv
// Purpose: clear/enable cycle counter that flags when it sits at TIMEOUT-1.
// Latency: tc is a decode of the registered count, valid the cycle the count lands.
// Backpressure: none; clear has priority over enable.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise step when enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter_fsm.sv
// Purpose: arbitrates icache/dcache requests onto one RAM port, data has strict priority.
// Latency: request seen in IDLE -> RAM strobe next cycle -> wait low the cycle after ACCESS (min 2).
// Backpressure: requesters hold until their wait drops; RAM stalls via BUSY, bounded by TIMEOUT.
module mem_arbiter_fsm
    import mem_arbiter_fsm_pkg::*;
#(
    parameter int    TIMEOUT  = ARB_TIMEOUT,
    parameter word_t ERR_WORD = ARB_ERR_WORD
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  ramstate_t   ramstate,
    output logic        merr
);

    arb_state_t state_q, state_d;
    arb_req_t   req_q, req_d;
    logic       iwait_q, iwait_d;
    logic       dwait_q, dwait_d;
    word_t      iload_q, iload_d;
    word_t      dload_q, dload_d;
    logic       ramren_q, ramren_d;
    logic       ramwen_q, ramwen_d;
    logic       merr_q, merr_d;
    word_t      resp_word;
    logic       cnt_clr;
    logic       cnt_en;
    logic       cnt_tc;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk (CLK),
        .rst (RST),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (cnt_tc)
    );

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        iwait_d   = 1'b1;
        dwait_d   = 1'b1;
        iload_d   = iload_q;
        dload_d   = dload_q;
        ramren_d  = 1'b0;
        ramwen_d  = 1'b0;
        merr_d    = merr_q;
        resp_word = ERR_WORD;
        cnt_clr   = 1'b1;
        cnt_en    = 1'b0;

        case (state_q)
            IDLE: begin
                // Data first: the MEM-stage access belongs to the older instruction.
                if (dREN || dWEN) begin
                    req_d    = '{addr: daddr, store: dstore, wen: dWEN, isdata: 1'b1};
                    ramren_d = ~dWEN;
                    ramwen_d = dWEN;
                    state_d  = D_REQ;
                end else if (iREN) begin
                    req_d    = '{addr: iaddr, store: '0, wen: 1'b0, isdata: 1'b0};
                    ramren_d = 1'b1;
                    state_d  = I_REQ;
                end
            end

            D_REQ, I_REQ: begin
                cnt_clr  = 1'b0;
                cnt_en   = 1'b1;
                ramren_d = ramren_q;
                ramwen_d = ramwen_q;
                // ACCESS is checked first so a late-but-valid answer beats the timeout.
                if (ramstate == ACCESS || ramstate == ERROR || cnt_tc) begin
                    ramren_d  = 1'b0;
                    ramwen_d  = 1'b0;
                    resp_word = (ramstate == ACCESS) ? ramload : ERR_WORD;
                    if (ramstate != ACCESS) begin
                        merr_d = 1'b1;
                    end
                    if (req_q.isdata) begin
                        // Writes leave the last load word visible.
                        if (!req_q.wen) begin
                            dload_d = resp_word;
                        end
                        dwait_d = 1'b0;
                        state_d = D_RESP;
                    end else begin
                        iload_d = resp_word;
                        iwait_d = 1'b0;
                        state_d = I_RESP;
                    end
                end
            end

            D_RESP, I_RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Single state/output register bank; reset drops any in-flight request silently.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            req_q    <= '0;
            iwait_q  <= 1'b1;
            dwait_q  <= 1'b1;
            iload_q  <= '0;
            dload_q  <= '0;
            ramren_q <= 1'b0;
            ramwen_q <= 1'b0;
            merr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            iwait_q  <= iwait_d;
            dwait_q  <= dwait_d;
            iload_q  <= iload_d;
            dload_q  <= dload_d;
            ramren_q <= ramren_d;
            ramwen_q <= ramwen_d;
            merr_q   <= merr_d;
        end
    end

    assign iwait    = iwait_q;
    assign dwait    = dwait_q;
    assign iload    = iload_q;
    assign dload    = dload_q;
    assign ramREN   = ramren_q;
    assign ramWEN   = ramwen_q;
    assign ramaddr  = req_q.addr;
    assign ramstore = req_q.store;
    assign merr     = merr_q;

endmodule

// File: tb/tb_mem_arbiter_fsm.sv
// Purpose: self-checking bench for mem_arbiter_fsm (vector table plus corner sequences).
// Latency: response words are scoreboarded and compared on each wait-low cycle.
// Backpressure: RAM BUSY/ACCESS/ERROR timing is scripted per vector.
module tb_mem_arbiter_fsm;
    import mem_arbiter_fsm_pkg::*;

    localparam int K_ACC = 0;
    localparam int K_ERR = 1;
    localparam int K_TMO = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    ramstate_t   ramstate;
    logic        merr;

    int n_checks = 0;
    int n_errors = 0;

    word_t iq[$];
    word_t dq[$];
    word_t mon_exp;
    logic  i_low_prev = 1'b0;
    logic  d_low_prev = 1'b0;

    typedef struct {
        logic  isdata;
        logic  wen;
        word_t addr;
        word_t store;
        int    kind;
        int    k;
        word_t ramload;
        word_t exp_data;
        int    exp_lat;
        logic  exp_merr;
    } vec_t;

    vec_t vecs[8];
    vec_t rst_vec;

    mem_arbiter_fsm dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .merr     (merr)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard: every wait-low cycle must match a queued expectation and last one cycle.
    always @(negedge CLK) begin
        if (iwait === 1'b0) begin
            check("iwait pulse width", {31'b0, i_low_prev}, 32'd0);
            if (iq.size() == 0) begin
                check("unexpected iwait pulse", 32'd1, 32'd0);
            end else begin
                mon_exp = iq.pop_front();
                check("iload", iload, mon_exp);
            end
        end
        if (dwait === 1'b0) begin
            check("dwait pulse width", {31'b0, d_low_prev}, 32'd0);
            if (dq.size() == 0) begin
                check("unexpected dwait pulse", 32'd1, 32'd0);
            end else begin
                mon_exp = dq.pop_front();
                check("dload", dload, mon_exp);
            end
        end
        i_low_prev = (iwait === 1'b0);
        d_low_prev = (dwait === 1'b0);
    end

    // Runs one transaction starting from an IDLE cycle (cycle 0) and leaves the DUT in IDLE.
    task automatic run_txn(input vec_t v, input string tag);
        int lat;
        lat = 0;
        if (v.isdata) begin
            dREN   = ~v.wen;
            dWEN   = v.wen;
            daddr  = v.addr;
            dstore = v.store;
            dq.push_back(v.exp_data);
        end else begin
            iREN  = 1'b1;
            iaddr = v.addr;
            iq.push_back(v.exp_data);
        end
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick();
            if (cyc == 1) begin
                check({tag, " ramREN"}, {31'b0, ramREN}, {31'b0, ~v.wen});
                check({tag, " ramWEN"}, {31'b0, ramWEN}, {31'b0, v.wen});
                check({tag, " ramaddr"}, ramaddr, v.addr);
                if (v.wen) check({tag, " ramstore"}, ramstore, v.store);
            end
            if ((v.isdata ? dwait : iwait) == 1'b0) begin
                lat = cyc;
                check({tag, " strobes in resp"}, {30'b0, ramREN, ramWEN}, 32'd0);
                iREN     = 1'b0;
                dREN     = 1'b0;
                dWEN     = 1'b0;
                ramstate = FREE;
                break;
            end
            ramstate = BUSY;
            if (cyc == v.k) begin
                if (v.kind == K_ACC) begin
                    ramstate = ACCESS;
                    ramload  = v.ramload;
                end else if (v.kind == K_ERR) begin
                    ramstate = ERROR;
                end
            end
        end
        iREN     = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        ramstate = FREE;
        check({tag, " latency"}, lat, v.exp_lat);
        check({tag, " merr"}, {31'b0, merr}, {31'b0, v.exp_merr});
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        //             isdata wen   addr          store          kind   k   ramload        exp_data       lat merr
        rst_vec  = '{1'b0, 1'b0, 32'h00000080, 32'h0,         K_ACC, 1,  32'h0A0B0C0D, 32'h0A0B0C0D, 2,  1'b0};
        vecs[0]  = '{1'b0, 1'b0, 32'h00000040, 32'h0,         K_ACC, 4,  32'h8C220004, 32'h8C220004, 5,  1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h00000200, 32'h0,         K_ACC, 1,  32'h12345678, 32'h12345678, 2,  1'b0};
        vecs[2]  = '{1'b1, 1'b1, 32'h00000100, 32'hDEADBEEF,  K_ACC, 2,  32'hFFFFFFFF, 32'h12345678, 3,  1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'h00000048, 32'h0,         K_ACC, 15, 32'hCAFEF00D, 32'hCAFEF00D, 16, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0000004C, 32'h0,         K_TMO, 0,  32'h0,        32'hBAD1BAD1, 16, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 32'h00000204, 32'h0,         K_ERR, 1,  32'h0,        32'hBAD1BAD1, 2,  1'b1};
        vecs[6]  = '{1'b1, 1'b0, 32'h00000300, 32'h0,         K_ACC, 3,  32'h000000A5, 32'h000000A5, 4,  1'b1};
        vecs[7]  = '{1'b0, 1'b0, 32'h00000050, 32'h0,         K_ACC, 2,  32'h01020304, 32'h01020304, 3,  1'b1};

        RST      = 1'b1;
        iREN     = 1'b1;
        iaddr    = 32'h00000080;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = 32'h0;
        dstore   = 32'h0;
        ramload  = 32'h0;
        ramstate = FREE;

        // Reset held two cycles with an instruction request pending.
        tick();
        tick();
        check("rst iwait", {31'b0, iwait}, 32'd1);
        check("rst dwait", {31'b0, dwait}, 32'd1);
        check("rst ramREN", {30'b0, ramREN, ramWEN}, 32'd0);
        check("rst merr", {31'b0, merr}, 32'd0);
        check("rst iload", iload, 32'd0);
        check("rst dload", dload, 32'd0);
        check("rst ramaddr", ramaddr, 32'd0);
        check("rst state", 32'(dut.state_q), 32'(IDLE));
        RST = 1'b0;
        run_txn(rst_vec, "post-reset fetch");

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Simultaneous write and fetch: write goes first, fetch afterwards.
        iREN   = 1'b1;
        iaddr  = 32'h00000044;
        dWEN   = 1'b1;
        daddr  = 32'h00000100;
        dstore = 32'hDEADBEEF;
        dq.push_back(32'h000000A5);
        iq.push_back(32'h55AA55AA);
        tick();
        check("simul ramWEN", {31'b0, ramWEN}, 32'd1);
        check("simul ramREN", {31'b0, ramREN}, 32'd0);
        check("simul ramaddr", ramaddr, 32'h00000100);
        check("simul ramstore", ramstore, 32'hDEADBEEF);
        ramstate = ACCESS;
        ramload  = 32'h11111111;
        tick();
        check("simul dwait", {31'b0, dwait}, 32'd0);
        check("simul iwait during write", {31'b0, iwait}, 32'd1);
        dWEN     = 1'b0;
        ramstate = FREE;
        tick();
        check("simul iwait idle", {31'b0, iwait}, 32'd1);
        check("simul ramREN idle", {31'b0, ramREN}, 32'd0);
        tick();
        check("simul fetch ramREN", {31'b0, ramREN}, 32'd1);
        check("simul fetch ramaddr", ramaddr, 32'h00000044);
        ramstate = ACCESS;
        ramload  = 32'h55AA55AA;
        tick();
        check("simul fetch iwait", {31'b0, iwait}, 32'd0);
        iREN     = 1'b0;
        ramstate = FREE;
        tick();

        // Write request withdrawn right after acceptance still completes.
        dWEN   = 1'b1;
        daddr  = 32'h00000180;
        dstore = 32'h0BADF00D;
        dq.push_back(32'h000000A5);
        tick();
        check("drop ramWEN c1", {31'b0, ramWEN}, 32'd1);
        dWEN     = 1'b0;
        ramstate = BUSY;
        tick();
        check("drop ramWEN c2", {31'b0, ramWEN}, 32'd1);
        check("drop ramaddr", ramaddr, 32'h00000180);
        check("drop ramstore", ramstore, 32'h0BADF00D);
        ramstate = ACCESS;
        tick();
        check("drop dwait", {31'b0, dwait}, 32'd0);
        ramstate = FREE;
        tick();

        // Reset during a data read abandons it with no response.
        dREN  = 1'b1;
        daddr = 32'h000001C0;
        tick();
        check("abort ramREN", {31'b0, ramREN}, 32'd1);
        RST      = 1'b1;
        dREN     = 1'b0;
        ramstate = BUSY;
        tick();
        check("abort dwait", {31'b0, dwait}, 32'd1);
        check("abort strobes", {30'b0, ramREN, ramWEN}, 32'd0);
        check("abort merr cleared", {31'b0, merr}, 32'd0);
        check("abort state", 32'(dut.state_q), 32'(IDLE));
        RST      = 1'b0;
        ramstate = FREE;
        tick();
        check("abort no late dwait", {31'b0, dwait}, 32'd1);
        check("abort ramREN after", {31'b0, ramREN}, 32'd0);
        tick();
        tick();

        check("iq drained", iq.size(), 32'd0);
        check("dq drained", dq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
